gb_cpu_regfile: RTL
===================

Name: gb_cpu_regfile

Overview:
- Architectural register file of the SM83 core: A, F, B, C, D, E, H, L, SP, PC and the internal temporary pair WZ.
- Sits directly upstream of gb_cpu_idu. Its 16-bit read port supplies the IDU operand and the address bus.
- Sits directly downstream of gb_cpu_idu. Its 16-bit write port takes the IDU result, for example PC+1 or HL-1.
- Also provides two 8-bit ALU operand reads, an 8-bit write port and per-flag writes.

Parameters:
PC_RESET, 16'h0000, PC value on reset (boot ROM entry).
SP_RESET, 16'h0000, SP value on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
r16_sel  in  reg16_sel_t  16-bit read select (BC, DE, HL, SP, PC, WZ, AF)
r16_out  out  16  selected pair, combinational from current state
r8a_sel  in  reg8_sel_t  8-bit read select A (A, F, B, C, D, E, H, L, W, Z)
r8a_out  out  8  selected byte
r8b_sel  in  reg8_sel_t  8-bit read select B
r8b_out  out  8  selected byte
w16_en  in  1  16-bit write enable
w16_sel  in  reg16_sel_t  16-bit write target
w16_data  in  16  16-bit write data (normally the IDU out)
w8_en  in  1  8-bit write enable
w8_sel  in  reg8_sel_t  8-bit write target
w8_data  in  8  8-bit write data (ALU result or data bus)
flags_we  in  4  per-flag write mask, bit order {Z,N,H,C}
flags_in  in  4  flag values, bit order {Z,N,H,C}
flags_out  out  4  F[7:4], always visible
pc_out  out  16  PC, always visible
sp_out  out  16  SP, always visible

Behaviour:
- Reset: while rst_n=0, all state is cleared immediately, without waiting for clk.
  - A, F, B, C, D, E, H, L, W and Z become 0.
  - PC becomes PC_RESET and SP becomes SP_RESET.
  - All outputs reflect these values within the same cycle.
- Reset asserted mid-write: the write is lost. Nothing is written on the rising edge at which rst_n is low.
- Reads:
  - Purely combinational from registered state.
  - No write-to-read bypass: a value written at edge N is visible after edge N.
  - Pair order is high:low: B:C, D:E, H:L, W:Z, A:F.
- F[3:0] reads 0 always. Writes to those bits are discarded on every path (w8, w16 with AF).
- Write precedence at one rising edge is applied in this order, each later step overriding earlier ones for the bits it touches:
  1. The w16 write is applied.
  2. The w8 write overrides the byte it targets. Example: w16 HL=0x1234 with w8 L=0xAA gives HL=0x12AA.
  3. flags_we bits override the matching F bits, including F from w8 or from w16 AF.
- SP and PC have no 8-bit path. They are written only through w16.
- Arithmetic: the block performs none. Wrap-around (0xFFFF to 0x0000) is the IDU's job; the regfile stores w16_data verbatim.
- Enables low: all state holds. Select inputs are ignored when the matching enable is low.
- Illegal select encodings:
  - On read, return 0.
  - On write, ignore the write.
- Throughput: one 16-bit, one 8-bit and one flag write per cycle, with no stall.

Decomposition:
- gb_cpu_common_pkg receives:
  - reg8_sel_t, enum: REG_A, REG_F, REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_W, REG_Z.
  - reg16_sel_t, enum: REG_BC, REG_DE, REG_HL, REG_SP, REG_PC, REG_WZ, REG_AF.
  - Flag bit index constants FLAG_Z=3, FLAG_N=2, FLAG_H=1, FLAG_C=0, applied to the 4-bit flag vectors.
- One sub-module is natural: gb_cpu_reg_pair. It is a 16-bit register with async active-low reset, a 16-bit write and independent high/low 8-bit byte writes, and it implements the w8-over-w16 precedence. Instantiate it for BC, DE, HL and WZ.
- AF, SP and PC are coded inline because of the F masking and the absence of an 8-bit path for SP/PC.

Test Plan:
- Reset: PC_RESET=0x0100, write BC=0xBEEF, then pulse rst_n low between clock edges -> all outputs change immediately: r16_out(BC)=0x0000, pc_out=0x0100, sp_out=0x0000, flags_out=0.
- IDU loop: r16_sel=HL=0xFFFF drives IDU_INC, w16_en=1 to HL with the IDU out -> next cycle HL=0x0000. Repeat with PC=0x0150 and IDU_DEC -> PC=0x014F.
- Collision: w16 DE=0x1234 and w8 E=0xAA at the same edge -> DE=0x12AA, D=0x12, E=0xAA.
- F masking: w16 AF=0x12FF -> A=0x12, F=0xF0. Then w8 F=0x0F with flags_we=4'b1000, flags_in=4'b1000 -> F=0x80.
- No bypass: write B=0x55 with r8a_sel=B held -> r8a_out keeps its old value until after the edge, then reads 0x55. Both read ports on the same register read identical values.
- Hold: all enables low for 10 cycles with random selects and data -> no state changes. Writes with illegal select encodings change nothing.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared SM83 core types: register select encodings, flag bit positions
// and the flag-merge helper used by the register file.
package gb_cpu_common_pkg;

    typedef enum logic [3:0] {
        REG_A = 4'd0,
        REG_F = 4'd1,
        REG_B = 4'd2,
        REG_C = 4'd3,
        REG_D = 4'd4,
        REG_E = 4'd5,
        REG_H = 4'd6,
        REG_L = 4'd7,
        REG_W = 4'd8,
        REG_Z = 4'd9
    } reg8_sel_t;

    typedef enum logic [2:0] {
        REG_BC = 3'd0,
        REG_DE = 3'd1,
        REG_HL = 3'd2,
        REG_SP = 3'd3,
        REG_PC = 3'd4,
        REG_WZ = 3'd5,
        REG_AF = 3'd6
    } reg16_sel_t;

    localparam int unsigned FLAG_Z = 32'd3;
    localparam int unsigned FLAG_N = 32'd2;
    localparam int unsigned FLAG_H = 32'd1;
    localparam int unsigned FLAG_C = 32'd0;

    // Per-bit override of a flag nibble: masked bits take the new value.
    function automatic logic [3:0] merge_flags(input logic [3:0] base,
                                               input logic [3:0] we,
                                               input logic [3:0] val);
        return (base & ~we) | (val & we);
    endfunction

endpackage

// File: rtl/gb_cpu_reg_pair.sv
// 16-bit register pair with a full-width write and independent byte writes;
// a byte write overrides the matching half of a same-cycle 16-bit write.
module gb_cpu_reg_pair (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w16_en,
    input  logic [15:0] w16_data,
    input  logic        wh_en,
    input  logic [7:0]  wh_data,
    input  logic        wl_en,
    input  logic [7:0]  wl_data,
    output logic [15:0] q
);

    logic [7:0] hi_r;
    logic [7:0] lo_r;
    logic [7:0] hi_nxt_s;
    logic [7:0] lo_nxt_s;

    assign hi_nxt_s = wh_en ? wh_data : (w16_en ? w16_data[15:8] : hi_r);
    assign lo_nxt_s = wl_en ? wl_data : (w16_en ? w16_data[7:0]  : lo_r);
    assign q        = {hi_r, lo_r};

    // Pair storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 8'h00;
            lo_r <= 8'h00;
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

endmodule

// File: rtl/gb_cpu_regfile.sv
// SM83 architectural register file: BC/DE/HL/WZ pairs, A/F with F[3:0] tied
// to zero, and SP/PC reachable only through the 16-bit port.
module gb_cpu_regfile
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  reg16_sel_t  r16_sel,
    output logic [15:0] r16_out,
    input  reg8_sel_t   r8a_sel,
    output logic [7:0]  r8a_out,
    input  reg8_sel_t   r8b_sel,
    output logic [7:0]  r8b_out,
    input  logic        w16_en,
    input  reg16_sel_t  w16_sel,
    input  logic [15:0] w16_data,
    input  logic        w8_en,
    input  reg8_sel_t   w8_sel,
    input  logic [7:0]  w8_data,
    input  logic [3:0]  flags_we,
    input  logic [3:0]  flags_in,
    output logic [3:0]  flags_out,
    output logic [15:0] pc_out,
    output logic [15:0] sp_out
);

    logic [15:0] bc_s, de_s, hl_s, wz_s;
    logic [7:0]  a_r, a_nxt_s;
    logic [3:0]  f_r, f_base_s, f_nxt_s;
    logic [15:0] sp_r, sp_nxt_s, pc_r, pc_nxt_s;
    logic [15:0] af_s;

    // Write strobes; an illegal select matches nothing and so writes nothing.
    function automatic logic hit16(input logic en, input reg16_sel_t sel,
                                   input reg16_sel_t tgt);
        return en && (sel == tgt);
    endfunction

    function automatic logic hit8(input logic en, input reg8_sel_t sel,
                                  input reg8_sel_t tgt);
        return en && (sel == tgt);
    endfunction

    gb_cpu_reg_pair u_bc (
        .clk(clk), .rst_n(rst_n),
        .w16_en(hit16(w16_en, w16_sel, REG_BC)), .w16_data(w16_data),
        .wh_en(hit8(w8_en, w8_sel, REG_B)), .wh_data(w8_data),
        .wl_en(hit8(w8_en, w8_sel, REG_C)), .wl_data(w8_data),
        .q(bc_s)
    );

    gb_cpu_reg_pair u_de (
        .clk(clk), .rst_n(rst_n),
        .w16_en(hit16(w16_en, w16_sel, REG_DE)), .w16_data(w16_data),
        .wh_en(hit8(w8_en, w8_sel, REG_D)), .wh_data(w8_data),
        .wl_en(hit8(w8_en, w8_sel, REG_E)), .wl_data(w8_data),
        .q(de_s)
    );

    gb_cpu_reg_pair u_hl (
        .clk(clk), .rst_n(rst_n),
        .w16_en(hit16(w16_en, w16_sel, REG_HL)), .w16_data(w16_data),
        .wh_en(hit8(w8_en, w8_sel, REG_H)), .wh_data(w8_data),
        .wl_en(hit8(w8_en, w8_sel, REG_L)), .wl_data(w8_data),
        .q(hl_s)
    );

    gb_cpu_reg_pair u_wz (
        .clk(clk), .rst_n(rst_n),
        .w16_en(hit16(w16_en, w16_sel, REG_WZ)), .w16_data(w16_data),
        .wh_en(hit8(w8_en, w8_sel, REG_W)), .wh_data(w8_data),
        .wl_en(hit8(w8_en, w8_sel, REG_Z)), .wl_data(w8_data),
        .q(wz_s)
    );

    // F keeps only the upper nibble; flag writes land last so they win.
    assign a_nxt_s  = hit8(w8_en, w8_sel, REG_A) ? w8_data :
                      (hit16(w16_en, w16_sel, REG_AF) ? w16_data[15:8] : a_r);
    assign f_base_s = hit8(w8_en, w8_sel, REG_F) ? w8_data[7:4] :
                      (hit16(w16_en, w16_sel, REG_AF) ? w16_data[7:4] : f_r);
    assign f_nxt_s  = merge_flags(f_base_s, flags_we, flags_in);
    assign sp_nxt_s = hit16(w16_en, w16_sel, REG_SP) ? w16_data : sp_r;
    assign pc_nxt_s = hit16(w16_en, w16_sel, REG_PC) ? w16_data : pc_r;

    // Inline A/F/SP/PC storage with asynchronous reset to their boot values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= 8'h00;
            f_r  <= 4'h0;
            sp_r <= SP_RESET;
            pc_r <= PC_RESET;
        end else begin
            a_r  <= a_nxt_s;
            f_r  <= f_nxt_s;
            sp_r <= sp_nxt_s;
            pc_r <= pc_nxt_s;
        end
    end

    assign af_s      = {a_r, f_r, 4'h0};
    assign flags_out = f_r;
    assign pc_out    = pc_r;
    assign sp_out    = sp_r;

    function automatic logic [7:0] sel8(input reg8_sel_t sel,
                                        input logic [15:0] af, input logic [15:0] bc,
                                        input logic [15:0] de, input logic [15:0] hl,
                                        input logic [15:0] wz);
        case (sel)
            REG_A:   return af[15:8];
            REG_F:   return af[7:0];
            REG_B:   return bc[15:8];
            REG_C:   return bc[7:0];
            REG_D:   return de[15:8];
            REG_E:   return de[7:0];
            REG_H:   return hl[15:8];
            REG_L:   return hl[7:0];
            REG_W:   return wz[15:8];
            REG_Z:   return wz[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // 16-bit read mux; unused encodings read as zero.
    always_comb begin
        r16_out = 16'h0000;
        case (r16_sel)
            REG_BC:  r16_out = bc_s;
            REG_DE:  r16_out = de_s;
            REG_HL:  r16_out = hl_s;
            REG_SP:  r16_out = sp_r;
            REG_PC:  r16_out = pc_r;
            REG_WZ:  r16_out = wz_s;
            REG_AF:  r16_out = af_s;
            default: r16_out = 16'h0000;
        endcase
    end

    assign r8a_out = sel8(r8a_sel, af_s, bc_s, de_s, hl_s, wz_s);
    assign r8b_out = sel8(r8b_sel, af_s, bc_s, de_s, hl_s, wz_s);

endmodule
